// File: rtl/seq_shift_add_mul_if.sv
// ============================================================================
// Module      : seq_shift_add_mul_if
// Description : Start/done handshake and external-adder bus of the sequential
//               shift-and-add multiplier. SEQ_MUL_MAC_EN adds acc_clr/acc_ovf.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_shift_add_mul_if #(
  parameter int W = 4
);
  logic           start;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic [W-1:0]   add_a;
  logic [W-1:0]   add_b;
  logic [W:0]     add_sum;
  logic           busy;
  logic           done;
  logic [2*W-1:0] product;
`ifdef SEQ_MUL_MAC_EN
  logic           acc_clr;
  logic           acc_ovf;

  modport master (
    output start, a, b, add_sum, acc_clr,
    input  add_a, add_b, busy, done, product, acc_ovf
  );
  modport slave (
    input  start, a, b, add_sum, acc_clr,
    output add_a, add_b, busy, done, product, acc_ovf
  );
`else
  modport master (
    output start, a, b, add_sum,
    input  add_a, add_b, busy, done, product
  );
  modport slave (
    input  start, a, b, add_sum,
    output add_a, add_b, busy, done, product
  );
`endif
endinterface

`default_nettype wire

// File: rtl/seq_shift_add_mul.sv
// ============================================================================
// Module      : seq_shift_add_mul
// Description : Unsigned W x W sequential shift-and-add multiplier driving an
//               external W-bit adder. Optional macro SEQ_MUL_MAC_EN turns the
//               product register into a wrapping accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_shift_add_mul #(
  parameter int W = 4
) (
  input  wire logic         clk,
  input  wire logic         rst,
  seq_shift_add_mul_if.slave bus
);

  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] C_LAST_STEP = CNT_W'(W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [W-1:0]     r_m;
  logic [W-1:0]     r_hi;
  logic [W-1:0]     r_q;
  logic [CNT_W-1:0] r_cnt;
  logic [2*W-1:0]   r_product;
  logic             r_busy;
  logic             r_done;

  // {HI,Q} after this cycle's add-and-shift; at the last step this is the product.
  logic [2*W-1:0]   w_step;
  assign w_step = {bus.add_sum, r_q[W-1:1]};

`ifdef SEQ_MUL_MAC_EN
  logic             r_acc_clr;
  logic             r_acc_ovf;
  logic [2*W-1:0]   w_base;
  logic [2*W:0]     w_acc;
  assign w_base      = r_acc_clr ? '0 : r_product;
  assign w_acc       = {1'b0, w_base} + {1'b0, w_step};
  assign bus.acc_ovf = r_acc_ovf;
`endif

  assign bus.add_a   = (r_state == S_RUN) ? r_hi : '0;
  assign bus.add_b   = (r_state == S_RUN && r_q[0]) ? r_m : '0;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.product = r_product;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_m       <= '0;
      r_hi      <= '0;
      r_q       <= '0;
      r_cnt     <= '0;
      r_product <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
`ifdef SEQ_MUL_MAC_EN
      r_acc_clr <= 1'b0;
      r_acc_ovf <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_m     <= bus.a;
            r_q     <= bus.b;
            r_hi    <= '0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_state <= S_RUN;
`ifdef SEQ_MUL_MAC_EN
            r_acc_clr <= bus.acc_clr;
            if (bus.acc_clr) begin
              r_acc_ovf <= 1'b0;
            end
`endif
          end
        end
        S_RUN: begin
          r_hi  <= w_step[2*W-1:W];
          r_q   <= w_step[W-1:0];
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == C_LAST_STEP) begin
`ifdef SEQ_MUL_MAC_EN
            r_product <= w_acc[2*W-1:0];
            r_acc_ovf <= r_acc_ovf | w_acc[2*W];
`else
            r_product <= w_step;
`endif
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seq_shift_add_mul.sv
// ============================================================================
// Module      : tb_seq_shift_add_mul
// Description : Directed self-checking bench for seq_shift_add_mul with an
//               arithmetic reference model; SEQ_MUL_MAC_EN enables MAC tests.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seq_shift_add_mul;
  localparam int W = 4;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  bit   cmp_en   = 0;
  logic [W-1:0] ab_seen [W];

  seq_shift_add_mul_if #(.W(W)) bus ();
  seq_shift_add_mul #(.W(W)) dut (.clk(clk), .rst(rst), .bus(bus));

  // External ripple-carry adder, carry-in tied to 0.
  assign bus.add_sum = {1'b0, bus.add_a} + {1'b0, bus.add_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction phase plus plain arithmetic on the operands.
  int             ph;
  int             ma, mb;
  logic [2*W-1:0] mprod;
  bit             movf, mclr;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0; ma = 0; mb = 0; mprod = '0; movf = 0; mclr = 0;
    end else if (ph == 0) begin
      if (bus.start) begin
        ma = int'(bus.a); mb = int'(bus.b); ph = 1;
`ifdef SEQ_MUL_MAC_EN
        mclr = bus.acc_clr;
        if (bus.acc_clr) movf = 0;
`endif
      end
    end else if (ph <= W) begin
      ph++;
      if (ph == W + 1) begin : finish_op
        int sum;
`ifdef SEQ_MUL_MAC_EN
        sum = (mclr ? 0 : int'(mprod)) + ma * mb;
        if (sum >= (1 << (2 * W))) movf = 1;
`else
        sum = ma * mb;
`endif
        mprod = sum[2*W-1:0];
      end
    end else begin
      ph = 0;
    end
  end

  always @(negedge clk) begin : compare
    int k, ea, eb;
    if (cmp_en) begin
      ea = 0; eb = 0;
      if (ph >= 1 && ph <= W) begin
        k  = ph - 1;
        eb = ((mb >> k) & 1) != 0 ? ma : 0;
        ea = (ma * (mb & ((1 << k) - 1))) >> k;
      end
      check("busy",    bus.busy,    (ph != 0) ? 1 : 0);
      check("done",    bus.done,    (ph == W + 1) ? 1 : 0);
      check("product", bus.product, mprod);
      check("add_a",   bus.add_a,   ea);
      check("add_b",   bus.add_b,   eb);
`ifdef SEQ_MUL_MAC_EN
      check("acc_ovf", bus.acc_ovf, movf);
`endif
    end
  end

  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic clr, input int exp_p);
    int n;
    @(negedge clk); #1;
    bus.start = 1'b1; bus.a = av; bus.b = bv;
`ifdef SEQ_MUL_MAC_EN
    bus.acc_clr = clr;
`else
    if (clr) $display("note: acc_clr ignored in this build");
`endif
    @(posedge clk); #1;
    bus.start = 1'b0; bus.a = ~av; bus.b = ~bv;
`ifdef SEQ_MUL_MAC_EN
    bus.acc_clr = 1'b1;
`endif
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n <= W) ab_seen[n-1] = bus.add_b;
    end while (!bus.done && n < 20);
    check("latency", n, W + 1);
    if (exp_p >= 0) check("product_lit", bus.product, exp_p);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int  n, n_done;
    time t_last;
    rst = 1'b1;
    bus.start = 1'b0; bus.a = '0; bus.b = '0;
`ifdef SEQ_MUL_MAC_EN
    bus.acc_clr = 1'b0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_busy",    bus.busy,    0);
    check("rst_done",    bus.done,    0);
    check("rst_product", bus.product, 0);
    check("rst_add_a",   bus.add_a,   0);
    check("rst_add_b",   bus.add_b,   0);
    #1 rst = 1'b0;
    cmp_en = 1;

    run_op(4'd15, 4'd15, 1'b0, 8'hE1);
    run_op(4'd9,  4'd7,  1'b0, 8'h3F);
    check("addb_step0", ab_seen[0], 9);
    check("addb_step1", ab_seen[1], 9);
    check("addb_step2", ab_seen[2], 9);
    check("addb_step3", ab_seen[3], 0);
    run_op(4'd0,  4'd13, 1'b0, 0);
    run_op(4'd13, 4'd0,  1'b0, 0);

    // start held high: back-to-back operations, operands disturbed mid-run
    @(negedge clk); #1;
    bus.start = 1'b1; bus.a = 4'd3; bus.b = 4'd5;
    @(posedge clk); #1;
    bus.a = 4'd15; bus.b = 4'd15;
    t_last = 0;
    for (int i = 0; i < 3; i++) begin
      n = 0;
      do begin @(negedge clk); n++; end while (!bus.done && n < 20);
      check("held_done",    bus.done,    1);
      check("held_product", bus.product, 15);
      if (i > 0) check("held_spacing", int'(($time - t_last) / 10), 6);
      t_last = $time;
      #1 bus.a = 4'd3; bus.b = 4'd5;
      if (i == 2) begin
        bus.start = 1'b0;
      end else begin
        @(negedge clk); @(negedge clk); #1;
        bus.a = 4'd15; bus.b = 4'd15;
      end
    end

    // reset aborts an in-flight operation
    run_op(4'd6, 4'd6, 1'b0, 8'h24);
    @(negedge clk); #1;
    bus.start = 1'b1; bus.a = 4'd2; bus.b = 4'd3;
    @(posedge clk); #1 bus.start = 1'b0;
    @(posedge clk); @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("abort_busy",    bus.busy,    0);
    check("abort_product", bus.product, 0);
    @(negedge clk); #1 rst = 1'b0;
    n_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) n_done++;
    end
    check("abort_no_done", n_done, 0);

`ifdef SEQ_MUL_MAC_EN
    run_op(4'd3, 4'd5, 1'b1, 15);
    run_op(4'd2, 4'd2, 1'b0, 19);
    check("mac_ovf_clear", bus.acc_ovf, 0);
    for (int i = 0; i < 292; i++) run_op(4'd15, 4'd15, 1'b0, -1);
    check("mac_ovf_set", bus.acc_ovf, 1);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
